sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 15 +
 rtl/sram_arbiter_if.sv | 24 ++
 rtl/sram_arbiter_id_fifo.sv | 57 +++++
 rtl/sram_arbiter.sv | 128 ++++++++++++
 tb/tb_sram_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared constants for the SRAM-like bus arbiter.
//   req_id_t  - requester identity carried through the outstanding-ID FIFO
//   SIZE_*    - transfer size encodings used on the *_size fields
package sram_arbiter_pkg;

  typedef enum logic {
    ID_INST = 1'b0,
    ID_DATA = 1'b1
  } req_id_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: one SRAM-like port (request channel + response channel).
//   master: drives req/wr/size/wstrb/addr/wdata, receives addr_ok/data_ok/rdata
//   slave : the opposite direction
interface sram_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_arbiter_id_fifo.sv
// arb_id_fifo: FIFO of 1-bit requester IDs for accepted-but-unanswered
// transactions.
//   clk, resetn       clock, async active-low reset (empties the FIFO)
//   push_i, push_id_i write an ID (ignored when full)
//   pop_i             drop the head entry (ignored when empty)
//   full_o, empty_o   occupancy flags
//   head_o            oldest outstanding ID
// DEPTH must be a power of two so pointers wrap naturally.
module arb_id_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push_i,
  input  logic push_id_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0] id_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = id_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        id_q[wr_ptr_q] <= push_id_i;
        wr_ptr_q       <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: merges an instruction and a data SRAM-like port onto one
// downstream SRAM-like port.
//   clk, resetn  clock, async active-low reset
//   inst (slave) instruction requester
//   data (slave) data requester
//   mem  (master) downstream memory
// The winner's request fields reach mem combinationally (no added latency).
// A stalled request (mem_addr_ok=0) locks the grant until accepted. Accepted
// transactions record their requester ID in arb_id_fifo so responses are
// routed back in acceptance order.
// Build option: define SRAM_ARB_ROUND_ROBIN_EN for alternating priority when
// both ports request; otherwise data always beats inst.
import sram_arbiter_pkg::*;

module sram_arbiter #(
  parameter int unsigned OUTSTANDING_DEPTH = 4
) (
  input  logic           clk,
  input  logic           resetn,
  sram_arbiter_if.slave  inst,
  sram_arbiter_if.slave  data,
  sram_arbiter_if.master mem
);
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t  state_q, state_d;
  req_id_t owner_q, owner_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  req_id_t prio_q, prio_d;
`endif

  req_id_t gnt_id;
  logic    gnt_req;
  logic    push, pop;
  logic    fifo_full, fifo_empty, fifo_head;

  // Grant selection: HOLD keeps the locked owner regardless of priority.
  always_comb begin
    gnt_id  = ID_DATA;
    gnt_req = 1'b0;
    if (state_q == ST_HOLD) begin
      gnt_id  = owner_q;
      gnt_req = (owner_q == ID_DATA) ? data.req : inst.req;
    end else begin
      gnt_req = inst.req | data.req;
      if (inst.req && data.req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        gnt_id = prio_q;
`else
        gnt_id = ID_DATA;
`endif
      end else if (inst.req) begin
        gnt_id = ID_INST;
      end else begin
        gnt_id = ID_DATA;
      end
    end
  end

  assign mem.req   = resetn & gnt_req & ~fifo_full;
  assign mem.wr    = (gnt_id == ID_DATA) ? data.wr    : inst.wr;
  assign mem.size  = (gnt_id == ID_DATA) ? data.size  : inst.size;
  assign mem.wstrb = (gnt_id == ID_DATA) ? data.wstrb : inst.wstrb;
  assign mem.addr  = (gnt_id == ID_DATA) ? data.addr  : inst.addr;
  assign mem.wdata = (gnt_id == ID_DATA) ? data.wdata : inst.wdata;

  assign push         = mem.req & mem.addr_ok;
  assign inst.addr_ok = push & (gnt_id == ID_INST);
  assign data.addr_ok = push & (gnt_id == ID_DATA);

  // Responses with no outstanding ID are dropped silently.
  assign pop          = mem.data_ok & ~fifo_empty;
  assign inst.data_ok = pop & (fifo_head == ID_INST);
  assign data.data_ok = pop & (fifo_head == ID_DATA);
  assign inst.rdata   = mem.rdata;
  assign data.rdata   = mem.rdata;

  // A pending but unaccepted request (stall or FIFO full) locks the grant.
  always_comb begin
    state_d = ST_IDLE;
    owner_d = owner_q;
    if (gnt_req && !push) begin
      state_d = ST_HOLD;
      owner_d = gnt_id;
    end
  end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  always_comb begin
    prio_d = prio_q;
    if (push) begin
      prio_d = (gnt_id == ID_DATA) ? ID_INST : ID_DATA;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      owner_q <= ID_DATA;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      prio_q  <= ID_DATA;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      prio_q  <= prio_d;
`endif
    end
  end

  arb_id_fifo #(
    .DEPTH(OUTSTANDING_DEPTH)
  ) u_id_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push_i   (push),
    .push_id_i(gnt_id),
    .pop_i    (pop),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .head_o   (fifo_head)
  );
endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int unsigned OD = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if inst_if ();
  sram_arbiter_if data_if ();
  sram_arbiter_if mem_if ();

  sram_arbiter #(
    .OUTSTANDING_DEPTH(OD)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .inst  (inst_if),
    .data  (data_if),
    .mem   (mem_if)
  );

  typedef struct {
    req_id_t     id;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_mon;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Response monitor: every mem_data_ok with an outstanding expectation must
  // appear on the expected port with the driven rdata; otherwise nothing.
  always @(negedge clk) begin
    if (mem_if.data_ok && sb.size() != 0) begin
      e_mon = sb.pop_front();
      chk("inst_data_ok", 32'(inst_if.data_ok), 32'(e_mon.id == ID_INST));
      chk("data_data_ok", 32'(data_if.data_ok), 32'(e_mon.id == ID_DATA));
      chk("rdata", (e_mon.id == ID_INST) ? inst_if.rdata : data_if.rdata, e_mon.rdata);
    end else if (inst_if.data_ok || data_if.data_ok) begin
      chk("spurious_data_ok", {30'b0, inst_if.data_ok, data_if.data_ok}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = SIZE_WORD;
    inst_if.wstrb = 4'h0; inst_if.addr = '0; inst_if.wdata = '0;
    data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = SIZE_WORD;
    data_if.wstrb = 4'h0; data_if.addr = '0; data_if.wdata = '0;
    mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = '0;
  endtask

  task automatic set_inst(input logic req, input logic [31:0] addr);
    inst_if.req = req; inst_if.wr = 1'b0; inst_if.addr = addr;
  endtask

  task automatic set_data(input logic req, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata);
    data_if.req = req; data_if.wr = wr; data_if.addr = addr; data_if.wdata = wdata;
    data_if.wstrb = wr ? 4'hf : 4'h0;
  endtask

  task automatic expect_accept(input string tag, input req_id_t id, input logic [31:0] addr,
                               input logic [31:0] rdata);
    exp_t e;
    chk({tag, "_mem_req"}, 32'(mem_if.req), 32'd1);
    chk({tag, "_mem_addr"}, mem_if.addr, addr);
    chk({tag, "_inst_addr_ok"}, 32'(inst_if.addr_ok), 32'(id == ID_INST));
    chk({tag, "_data_addr_ok"}, 32'(data_if.addr_ok), 32'(id == ID_DATA));
    e.id = id;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic drain(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      mem_if.data_ok = 1'b1;
      mem_if.rdata = (sb.size() != 0) ? sb[0].rdata : 32'h0;
      sample();
    end
    tick();
    mem_if.data_ok = 1'b0;
    chk("sb_drained", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_id_t exp_id;

    // Reset: requests present but everything held off.
    idle();
    set_inst(1'b1, 32'h0000_1000);
    mem_if.addr_ok = 1'b1;
    sample();
    chk("rst_mem_req", 32'(mem_if.req), 32'd0);
    chk("rst_inst_addr_ok", 32'(inst_if.addr_ok), 32'd0);
    chk("rst_data_addr_ok", 32'(data_if.addr_ok), 32'd0);
    chk("rst_mem_addr", mem_if.addr, 32'h0000_1000);
    chk("rst_count", 32'(dut.u_id_fifo.count_q), 32'd0);
    idle();
    tick();
    resetn = 1'b1;
    tick();

    // Both request together: data first, then inst; responses in that order.
    set_inst(1'b1, 32'h0000_0100);
    set_data(1'b1, 1'b1, 32'h0000_0200, 32'hCAFE_F00D);
    mem_if.addr_ok = 1'b1;
    sample();
    chk("t1_mem_wr", 32'(mem_if.wr), 32'd1);
    chk("t1_mem_wdata", mem_if.wdata, 32'hCAFE_F00D);
    chk("t1_mem_wstrb", 32'(mem_if.wstrb), 32'hf);
    expect_accept("t1_c0", ID_DATA, 32'h0000_0200, 32'hD000_0001);
    tick();
    set_data(1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    expect_accept("t1_c1", ID_INST, 32'h0000_0100, 32'hA000_0001);
    tick();
    set_inst(1'b0, 32'h0);
    mem_if.addr_ok = 1'b0;
    drain(2);

    // Stall: inst locked through 3 refused cycles despite higher-priority data.
    tick();
    set_inst(1'b1, 32'h0000_0300);
    sample();
    chk("t2_c0_mem_req", 32'(mem_if.req), 32'd1);
    chk("t2_c0_inst_addr_ok", 32'(inst_if.addr_ok), 32'd0);
    tick();
    set_data(1'b1, 1'b0, 32'h0000_0400, 32'h0);
    sample();
    chk("t2_c1_mem_addr", mem_if.addr, 32'h0000_0300);
    chk("t2_c1_data_addr_ok", 32'(data_if.addr_ok), 32'd0);
    tick();
    sample();
    chk("t2_c2_mem_addr", mem_if.addr, 32'h0000_0300);
    tick();
    mem_if.addr_ok = 1'b1;
    sample();
    expect_accept("t2_c3", ID_INST, 32'h0000_0300, 32'hA000_0002);
    tick();
    set_inst(1'b0, 32'h0);
    sample();
    expect_accept("t2_c4", ID_DATA, 32'h0000_0400, 32'hD000_0002);
    tick();
    set_data(1'b0, 1'b0, 32'h0, 32'h0);
    mem_if.addr_ok = 1'b0;
    drain(2);

    // FIFO full: fifth request blocked until one response pops.
    tick();
    mem_if.addr_ok = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i > 0) tick();
      set_inst(1'b1, 32'h0000_1000 + 32'(4 * i));
      sample();
      expect_accept("t3_fill", ID_INST, 32'h0000_1000 + 32'(4 * i), 32'hB000_0000 + 32'(i));
    end
    tick();
    set_inst(1'b1, 32'h0000_1010);
    sample();
    chk("t3_full_mem_req", 32'(mem_if.req), 32'd0);
    chk("t3_full_inst_addr_ok", 32'(inst_if.addr_ok), 32'd0);
    chk("t3_full_count", 32'(dut.u_id_fifo.count_q), OD);
    tick();
    mem_if.data_ok = 1'b1;
    mem_if.rdata = sb[0].rdata;
    sample();
    chk("t3_pop_mem_req", 32'(mem_if.req), 32'd0);
    tick();
    mem_if.data_ok = 1'b0;
    sample();
    expect_accept("t3_fifth", ID_INST, 32'h0000_1010, 32'hB000_0004);
    tick();
    set_inst(1'b0, 32'h0);
    mem_if.addr_ok = 1'b0;
    drain(4);

    // Simultaneous pop and push at count=2.
    tick();
    mem_if.addr_ok = 1'b1;
    set_data(1'b1, 1'b1, 32'h0000_2000, 32'h1111_1111);
    sample();
    expect_accept("t4_a", ID_DATA, 32'h0000_2000, 32'h1234_5678);
    tick();
    set_data(1'b1, 1'b1, 32'h0000_2004, 32'h2222_2222);
    sample();
    expect_accept("t4_b", ID_DATA, 32'h0000_2004, 32'hD000_0004);
    tick();
    set_data(1'b0, 1'b0, 32'h0, 32'h0);
    set_inst(1'b1, 32'h0000_2008);
    mem_if.data_ok = 1'b1;
    mem_if.rdata = 32'h1234_5678;
    sample();
    chk("t4_count_before", 32'(dut.u_id_fifo.count_q), 32'd2);
    expect_accept("t4_c", ID_INST, 32'h0000_2008, 32'hA000_0004);
    tick();
    set_inst(1'b0, 32'h0);
    mem_if.data_ok = 1'b0;
    mem_if.addr_ok = 1'b0;
    sample();
    chk("t4_count_after", 32'(dut.u_id_fifo.count_q), 32'd2);
    drain(2);

    // Reset with 3 outstanding: later responses are dropped.
    tick();
    mem_if.addr_ok = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      if (i > 0) tick();
      set_inst(1'b1, 32'h0000_3000 + 32'(4 * i));
      sample();
      expect_accept("t5_fill", ID_INST, 32'h0000_3000 + 32'(4 * i), 32'hE000_0000);
    end
    tick();
    set_inst(1'b0, 32'h0);
    mem_if.addr_ok = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_rst_count", 32'(dut.u_id_fifo.count_q), 32'd0);
    sb.delete();
    sample();
    tick();
    resetn = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      mem_if.data_ok = 1'b1;
      mem_if.rdata = 32'hE000_0000;
      sample();
      chk("t5_inst_data_ok", 32'(inst_if.data_ok), 32'd0);
      chk("t5_data_data_ok", 32'(data_if.data_ok), 32'd0);
    end
    tick();
    mem_if.data_ok = 1'b0;
    sample();
    chk("t5_count", 32'(dut.u_id_fifo.count_q), 32'd0);

    // Both requesting continuously for 6 cycles.
    tick();
    set_inst(1'b1, 32'h0000_4000);
    set_data(1'b1, 1'b0, 32'h0000_5000, 32'h0);
    mem_if.addr_ok = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      if (i > 0) tick();
      sample();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      exp_id = (i % 2 == 0) ? ID_DATA : ID_INST;
`else
      exp_id = ID_DATA;
`endif
      expect_accept("t6", exp_id, (exp_id == ID_DATA) ? 32'h0000_5000 : 32'h0000_4000,
                    32'hF000_0000 + 32'(i));
      if (i == 3) begin
        // keep FIFO below full: nothing to do in a depth-4 run beyond 4 entries
      end
      if (i == 3) begin
        tick();
        set_inst(1'b0, 32'h0);
        set_data(1'b0, 1'b0, 32'h0, 32'h0);
        mem_if.addr_ok = 1'b0;
        drain(4);
        tick();
        set_inst(1'b1, 32'h0000_4000);
        set_data(1'b1, 1'b0, 32'h0000_5000, 32'h0);
        mem_if.addr_ok = 1'b1;
      end
    end
    tick();
    idle();
    drain(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
